// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and defaults for the two-master data memory arbiter.
// The state encoding and the grant helper are used by the arbiter and its bus interface.
package data_mem_arb_pkg;

    localparam int DEF_AW = 8;
    localparam int DEF_DW = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    // One-hot owner view of a state; IDLE (and any unused code) owns nothing.
    function automatic logic [1:0] state_gnt(input arb_state_e s);
        logic [1:0] g;
        g = 2'b00;
        case (s)
            OWN0:    g = 2'b01;
            OWN1:    g = 2'b10;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Wishbone-style classic bus bundle: one master/slave pair of cycle, strobe,
// write enable, address, write/read data and acknowledge.
interface data_mem_arbiter_if
    import data_mem_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);
    logic          cyc;
    logic          stb;
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] wdat;
    logic [DW-1:0] rdat;
    logic          ack;

    modport master (output cyc, stb, we, adr, wdat, input  rdat, ack);
    modport slave  (input  cyc, stb, we, adr, wdat, output rdat, ack);
endinterface

// File: rtl/data_mem_arbiter_rr2.sv
// Combinational two-way round-robin pick: a lone requester wins, and on a tie
// the master that was not granted last wins.
module arb_rr2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);
    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end
endmodule

// File: rtl/data_mem_arbiter.sv
// Two-master arbiter in front of the data memory: registered round-robin grant,
// no preemption, and a forced idle bus cycle on every handover.
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_adr_i,
    input  logic [DW-1:0] m0_dat_i,
    output logic [DW-1:0] m0_dat_o,
    output logic          m0_ack_o,
    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_adr_i,
    input  logic [DW-1:0] m1_dat_i,
    output logic [DW-1:0] m1_dat_o,
    output logic          m1_ack_o,
    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic          s_we_o,
    output logic [AW-1:0] s_adr_o,
    output logic [DW-1:0] s_dat_o,
    input  logic [DW-1:0] s_dat_i,
    input  logic          s_ack_i,
    output logic [1:0]    gnt_o
);
    arb_state_e state_q, state_d;
    logic       last_q, last_d;
    logic [1:0] gnt_q, gnt_d;
    logic [1:0] pick;
    logic       own0, own1;

    arb_rr2 u_rr (
        .req  ({m1_cyc_i, m0_cyc_i}),
        .last (last_q),
        .gnt  (pick)
    );

    // Ownership only ends when the owner drops cyc, and that cycle already shows
    // s_cyc_o=0, so the slave always sees an idle cycle between owners.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (pick[0]) begin
                    state_d = OWN0;
                    last_d  = 1'b0;
                end else if (pick[1]) begin
                    state_d = OWN1;
                    last_d  = 1'b1;
                end
            end
            OWN0: begin
                if (!m0_cyc_i) begin
                    if (m1_cyc_i) begin
                        state_d = OWN1;
                        last_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            OWN1: begin
                if (!m1_cyc_i) begin
                    if (m0_cyc_i) begin
                        state_d = OWN0;
                        last_d  = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        gnt_d = state_gnt(state_d);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            gnt_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
        end
    end

    assign own0  = (state_q == OWN0);
    assign own1  = (state_q == OWN1);
    assign gnt_o = gnt_q;

    // A strobe without cyc is not a bus request, so it never reaches the slave.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        m0_dat_o = '0;
        m1_dat_o = '0;
        if (own0) begin
            s_cyc_o  = m0_cyc_i;
            s_stb_o  = m0_cyc_i & m0_stb_i;
            s_we_o   = m0_we_i;
            s_adr_o  = m0_adr_i;
            s_dat_o  = m0_dat_i;
            m0_dat_o = s_dat_i;
        end else if (own1) begin
            s_cyc_o  = m1_cyc_i;
            s_stb_o  = m1_cyc_i & m1_stb_i;
            s_we_o   = m1_we_i;
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            m1_dat_o = s_dat_i;
        end
    end

    assign m0_ack_o = s_ack_i & own0 & m0_cyc_i & m0_stb_i;
    assign m1_ack_o = s_ack_i & own1 & m1_cyc_i & m1_stb_i;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a 256x8 data memory model that acks
// writes combinationally and reads one cycle after the strobe.
module tb_data_mem_arbiter;
    import data_mem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    data_mem_arbiter_if #(.AW(8), .DW(8)) m0_bus ();
    data_mem_arbiter_if #(.AW(8), .DW(8)) m1_bus ();
    data_mem_arbiter_if #(.AW(8), .DW(8)) s_bus ();
    logic [1:0] gnt;

    always #5 clk = ~clk;

    data_mem_arbiter #(.AW(8), .DW(8)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .m0_cyc_i (m0_bus.cyc),
        .m0_stb_i (m0_bus.stb),
        .m0_we_i  (m0_bus.we),
        .m0_adr_i (m0_bus.adr),
        .m0_dat_i (m0_bus.wdat),
        .m0_dat_o (m0_bus.rdat),
        .m0_ack_o (m0_bus.ack),
        .m1_cyc_i (m1_bus.cyc),
        .m1_stb_i (m1_bus.stb),
        .m1_we_i  (m1_bus.we),
        .m1_adr_i (m1_bus.adr),
        .m1_dat_i (m1_bus.wdat),
        .m1_dat_o (m1_bus.rdat),
        .m1_ack_o (m1_bus.ack),
        .s_cyc_o  (s_bus.cyc),
        .s_stb_o  (s_bus.stb),
        .s_we_o   (s_bus.we),
        .s_adr_o  (s_bus.adr),
        .s_dat_o  (s_bus.wdat),
        .s_dat_i  (s_bus.rdat),
        .s_ack_i  (s_bus.ack),
        .gnt_o    (gnt)
    );

    // Data memory model
    logic [7:0] mem [256];
    logic [7:0] rdat_q;
    logic       rd_ack_q;

    always @(posedge clk) begin
        if (!rst_n) begin
            mem[8'h20] <= 8'h5A;
            mem[8'h21] <= 8'h3C;
        end else if (s_bus.cyc && s_bus.stb && s_bus.we) begin
            mem[s_bus.adr] <= s_bus.wdat;
        end
        if (s_bus.cyc && s_bus.stb && !s_bus.we) rdat_q <= mem[s_bus.adr];
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_ack_q <= 1'b0;
        else        rd_ack_q <= s_bus.cyc & s_bus.stb & ~s_bus.we & ~rd_ack_q;
    end

    assign s_bus.rdat = rdat_q;
    assign s_bus.ack  = (s_bus.cyc & s_bus.stb & s_bus.we) | rd_ack_q;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_m0(input logic cyc, input logic stb, input logic we,
                            input logic [7:0] adr, input logic [7:0] dat);
        m0_bus.cyc = cyc; m0_bus.stb = stb; m0_bus.we = we;
        m0_bus.adr = adr; m0_bus.wdat = dat;
    endtask

    task automatic drive_m1(input logic cyc, input logic stb, input logic we,
                            input logic [7:0] adr, input logic [7:0] dat);
        m1_bus.cyc = cyc; m1_bus.stb = stb; m1_bus.we = we;
        m1_bus.adr = adr; m1_bus.wdat = dat;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         nev;
        logic       exp_own;
        logic [1:0] prev_g;
        logic [1:0] ackp;

        // Reset with both masters requesting: m0 write A5@10, m1 read @21
        rst_n = 1'b0;
        drive_m0(1'b1, 1'b1, 1'b1, 8'h10, 8'hA5);
        drive_m1(1'b1, 1'b1, 1'b0, 8'h21, 8'h00);
        repeat (3) tick();
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_s_cyc", s_bus.cyc, 1'b0);
        chk("rst_s_stb", s_bus.stb, 1'b0);
        chk("rst_s_we", s_bus.we, 1'b0);
        chk("rst_s_adr", s_bus.adr, 8'h00);
        chk("rst_s_dat", s_bus.wdat, 8'h00);
        chk("rst_m0_ack", m0_bus.ack, 1'b0);
        chk("rst_m1_ack", m1_bus.ack, 1'b0);
        chk("rst_m0_dat", m0_bus.rdat, 8'h00);
        chk("rst_m1_dat", m1_bus.rdat, 8'h00);
        rst_n = 1'b1;

        // Tie from reset: m0 wins, write acked in first owned cycle
        tick();
        chk("tie_gnt", gnt, 2'b01);
        chk("wr_s_cyc", s_bus.cyc, 1'b1);
        chk("wr_s_we", s_bus.we, 1'b1);
        chk("wr_s_adr", s_bus.adr, 8'h10);
        chk("wr_s_dat", s_bus.wdat, 8'hA5);
        chk("wr_m0_ack", m0_bus.ack, 1'b1);
        chk("wr_m1_ack", m1_bus.ack, 1'b0);
        tick();
        drive_m0(1'b0, 1'b0, 1'b0, 8'h10, 8'h00);
        #1;
        chk("gap_s_cyc", s_bus.cyc, 1'b0);
        chk("gap_gnt", gnt, 2'b01);
        chk("gap_m0_ack", m0_bus.ack, 1'b0);

        // Handover to m1 after a write: read acked in second owned cycle
        tick();
        chk("h1_gnt", gnt, 2'b10);
        chk("h1_s_adr", s_bus.adr, 8'h21);
        chk("h1_s_we", s_bus.we, 1'b0);
        chk("h1_m1_ack_first", m1_bus.ack, 1'b0);
        tick();
        chk("h1_m1_ack", m1_bus.ack, 1'b1);
        chk("h1_m1_dat", m1_bus.rdat, 8'h3C);
        chk("h1_m0_ack", m0_bus.ack, 1'b0);
        chk("h1_m0_dat", m0_bus.rdat, 8'h00);

        // m1 releases but leaves a stray strobe; m0 requests read of 10
        tick();
        drive_m1(1'b0, 1'b1, 1'b0, 8'h21, 8'h00);
        drive_m0(1'b1, 1'b1, 1'b0, 8'h10, 8'h00);
        #1;
        chk("stray_gnt", gnt, 2'b10);
        chk("stray_s_cyc", s_bus.cyc, 1'b0);
        chk("stray_s_stb", s_bus.stb, 1'b0);
        chk("stray_m1_ack", m1_bus.ack, 1'b0);
        tick();
        chk("rd_gnt", gnt, 2'b01);
        chk("rd_s_adr", s_bus.adr, 8'h10);
        chk("rd_m0_ack_first", m0_bus.ack, 1'b0);
        tick();
        chk("rd_m0_ack", m0_bus.ack, 1'b1);
        chk("rd_m0_dat", m0_bus.rdat, 8'hA5);
        tick();
        drive_m0(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive_m1(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        chk("rd_gap_s_cyc", s_bus.cyc, 1'b0);
        tick();
        chk("idle_gnt", gnt, 2'b00);

        // Handover hazard: m0 read 20, then m1 read 21 right behind it
        drive_m0(1'b1, 1'b1, 1'b0, 8'h20, 8'h00);
        tick();
        drive_m1(1'b1, 1'b1, 1'b0, 8'h21, 8'h00);
        #1;
        chk("hz_gnt0", gnt, 2'b01);
        chk("hz_m0_ack_first", m0_bus.ack, 1'b0);
        tick();
        chk("hz_m0_ack", m0_bus.ack, 1'b1);
        chk("hz_m0_dat", m0_bus.rdat, 8'h5A);
        chk("hz_m1_ack_wait", m1_bus.ack, 1'b0);
        tick();
        drive_m0(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        chk("hz_gap_s_cyc", s_bus.cyc, 1'b0);
        tick();
        chk("hz_gnt1", gnt, 2'b10);
        chk("hz_m1_ack_first", m1_bus.ack, 1'b0);
        tick();
        chk("hz_m1_ack", m1_bus.ack, 1'b1);
        chk("hz_m1_dat", m1_bus.rdat, 8'h3C);
        tick();
        drive_m1(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        chk("hz_idle_gnt", gnt, 2'b00);

        // Fairness: both re-request writes after a one-cycle drop; grants alternate
        nev     = 0;
        exp_own = 1'b0;
        prev_g  = 2'b00;
        ackp    = 2'b00;
        for (int c = 0; c < 80 && nev < 8; c++) begin
            drive_m0(~ackp[0], ~ackp[0], 1'b1, 8'h40, 8'(c));
            drive_m1(~ackp[1], ~ackp[1], 1'b1, 8'h41, 8'(c));
            #1;
            ackp = {m1_bus.ack, m0_bus.ack};
            if (gnt != 2'b00 && gnt != prev_g) begin
                chk("fair_gnt", gnt, exp_own ? 2'b10 : 2'b01);
                exp_own = ~exp_own;
                nev++;
            end
            prev_g = gnt;
            tick();
        end
        chk("fair_count", nev, 8);
        drive_m0(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive_m1(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (3) tick();
        chk("fair_idle_gnt", gnt, 2'b00);

        // Mid-cycle reset while m1 owns the bus with a pending read
        drive_m1(1'b1, 1'b1, 1'b0, 8'h21, 8'h00);
        tick();
        chk("mr_gnt1", gnt, 2'b10);
        chk("mr_m1_ack_first", m1_bus.ack, 1'b0);
        rst_n = 1'b0;
        drive_m0(1'b1, 1'b1, 1'b0, 8'h10, 8'h00);
        #1;
        chk("mr_async_gnt", gnt, 2'b00);
        chk("mr_async_s_cyc", s_bus.cyc, 1'b0);
        chk("mr_async_m1_ack", m1_bus.ack, 1'b0);
        tick();
        chk("mr_hold_m1_ack", m1_bus.ack, 1'b0);
        chk("mr_hold_gnt", gnt, 2'b00);
        rst_n = 1'b1;
        #1;
        chk("mr_rel_gnt", gnt, 2'b00);
        chk("mr_rel_m1_ack", m1_bus.ack, 1'b0);
        tick();
        chk("mr_first_gnt", gnt, 2'b01);
        chk("mr_first_m1_ack", m1_bus.ack, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
